// File: rtl/data_mem_resp.sv
// Load/store responder: byte-addressed word array with a valid/ready request and response handshake.
// Optional wait states between acceptance and response are enabled by defining DMEM_WAIT_STATE_EN.
module data_mem_resp #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DMEM_WAIT_STATE_EN
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {StIdle, StResp} state_e;
`endif

  state_e state_q, state_d;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          req_err;
  logic [29:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic [3:0]    be;
  logic [31:0]   wlane;

  logic [31:0] raw_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic        err_q;

  logic [31:0] shifted;
  logic [31:0] ext;

  assign req_ready = (state_q == StIdle);
  // A request present while rst is high must not be taken, even from IDLE.
  assign accept    = req_valid && req_ready && !rst;
  assign word_idx  = req_addr[31:2];
  assign mem_idx   = req_addr[AW+1:2];

  always_comb begin
    req_err = 1'b0;
    be      = 4'b0000;
    wlane   = req_wdata;
    unique case (req_size)
      2'b00: begin
        be    = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_err = req_addr[0];
        be      = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_err = |req_addr[1:0];
        be      = 4'b1111;
      end
      default: req_err = 1'b1;
    endcase
    if ({2'b00, word_idx} >= DEPTH) req_err = 1'b1;
  end

  // Array is intentionally not reset; stores commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      raw_q <= mem[mem_idx];
      if (req_we && !req_err) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[mem_idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef DMEM_WAIT_STATE_EN
      cnt_q   <= cnt_d;
`endif
      if (accept) begin
        off_q  <= req_addr[1:0];
        size_q <= req_size;
        uns_q  <= req_unsigned;
        we_q   <= req_we;
        err_q  <= req_err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef DMEM_WAIT_STATE_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef DMEM_WAIT_STATE_EN
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CW'(WAIT_CYCLES);
          end
`else
          state_d = StResp;
`endif
        end
      end
`ifdef DMEM_WAIT_STATE_EN
      StWait: begin
        if (cnt_q == '0) state_d = StResp;
        else             cnt_d   = cnt_q - 1'b1;
      end
`endif
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shifted = raw_q >> {off_q, 3'b000};
    ext     = 32'h0;
    unique case (size_q)
      2'b00:   ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      2'b10:   ext = shifted;
      default: ext = 32'h0;
    endcase
  end

  assign resp_valid = (state_q == StResp);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !err_q && !we_q) ? ext : 32'h0;

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words in the internal data array.
REQ-002 Parameter WAIT_CYCLES, default 2: extra response latency in cycles; used only when DMEM_WAIT_STATE_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-011 req_wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  core accepts the response.
REQ-014 resp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-015 resp_err  output  1  misaligned, out-of-range or illegal-size request.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready = 1 only in IDLE, and resp_valid = 1 only in RESP.
REQ-017 A request SHALL be accepted on a rising edge where req_valid && req_ready; request fields are sampled at that edge only.
REQ-018 Error SHALL be set when any of these holds: req_size = 11; half with addr[0] = 1; word with addr[1:0] != 00; or word index addr[31:2] >= DEPTH.
REQ-019 An accepted error-free store SHALL write the array at the acceptance edge, affecting only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2 and addr[1]*2+1; word: all 4 lanes).
REQ-020 An errored request SHALL NOT modify the array.
REQ-021 Load data SHALL be read from the array at the acceptance edge and registered, then shifted down by the lane offset and extended per req_size/req_unsigned.
REQ-022 Without wait states, the FSM SHALL go IDLE -> RESP at the acceptance edge, so resp_valid is high in the cycle after acceptance.
REQ-023 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until a rising edge with resp_ready = 1, then return to IDLE.
REQ-024 No new request SHALL be accepted in the same cycle a response completes; back-to-back throughput is therefore one request per 2 cycles without wait states.
REQ-025 A load following a store to the same address SHALL return the stored data.
REQ-026 Outside RESP, resp_rdata and resp_err SHALL be 0.

Reset
REQ-027 With rst high at a rising edge, the FSM SHALL enter IDLE, the wait counter SHALL clear, and resp_valid, resp_rdata and resp_err SHALL be 0; req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 Reset in WAIT or RESP SHALL discard the pending response; a store already committed at acceptance SHALL remain in the array.
REQ-029 Array contents SHALL NOT be reset; a req_valid present in a cycle where rst is high at the edge SHALL NOT be accepted.

Configuration
REQ-030 When macro DMEM_WAIT_STATE_EN is defined, acceptance SHALL move the FSM to WAIT, where a counter loaded with WAIT_CYCLES counts down; at count 0 the FSM moves to RESP (resp_valid first high WAIT_CYCLES+1 cycles after acceptance).
REQ-031 With DMEM_WAIT_STATE_EN defined and WAIT_CYCLES = 0, the FSM SHALL behave as if the macro were undefined.
REQ-032 When DMEM_WAIT_STATE_EN is undefined, the WAIT state and counter SHALL NOT be synthesized and WAIT_CYCLES SHALL be ignored.

Verification
REQ-033 Store word 0xDEADBEEF at 0x10, then load word from 0x10 -> resp_rdata = 0xDEADBEEF, resp_err = 0, with resp_valid one cycle after acceptance (macro undefined).
REQ-034 Store byte 0x80 at 0x11, then signed byte load from 0x11 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load from 0x10 -> 0xDEAD80EF.
REQ-035 Half load from 0x13 and word store to 0x400 with DEPTH = 256 -> resp_err = 1, resp_rdata = 0; word at 0x400 reads unchanged through a legal alias check and the array is unmodified.
REQ-036 Hold resp_ready = 0 for 3 cycles in RESP -> resp_valid and data stay stable and req_ready stays 0; the response completes on the first edge with resp_ready = 1.
REQ-037 Macro defined, WAIT_CYCLES = 2: load accepted at edge N -> resp_valid first high after edge N+3; rst asserted at edge N+1 -> no response, and req_ready = 1 after rst deasserts.
